// File: rtl/svm_sv_accumulator_pkg.sv
// Shared Q16.16 constants and FSM state type for the SVM accumulator slice.
package svm_pkg;
    localparam int          DATA_W       = 32;
    localparam int          FRAC_BITS    = 16;
    localparam logic [31:0] Q_ONE        = 32'h0001_0000;
    localparam logic [31:0] Q_MAX        = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN        = 32'h8000_0000;
    localparam logic [31:0] BIAS_DEFAULT = 32'hFFFA_0000;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINAL, OUTPUT} acc_state_t;
endpackage

// File: rtl/svm_sv_accumulator_if.sv
// Pair stream in, decision result out; both valid/ready handshakes.
interface svm_sv_accumulator_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alpha;
    logic [DATA_W-1:0] in_kernel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] decision_value;
    logic              classification_result;
    logic              sat_flag;

    modport master (
        output in_valid, in_alpha, in_kernel, out_ready,
        input  in_ready, out_valid, decision_value, classification_result, sat_flag
    );
    modport slave (
        input  in_valid, in_alpha, in_kernel, out_ready,
        output in_ready, out_valid, decision_value, classification_result, sat_flag
    );
endinterface

// File: rtl/svm_sat_narrow.sv
// Narrows a signed Q.32 accumulator value to Q16.16 with saturation.
module svm_sat_narrow #(
    parameter int ACC_W     = 80,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic signed [ACC_W-1:0]  din,
    output logic signed [DATA_W-1:0] dout,
    output logic                     sat
);
    localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] MIN_EXT = ~MAX_EXT;

    // Arithmetic shift truncates toward negative infinity.
    logic signed [ACC_W-1:0] shifted;
    assign shifted = din >>> FRAC_BITS;

    always_comb begin
        dout = shifted[DATA_W-1:0];
        sat  = 1'b0;
        if (shifted > MAX_EXT) begin
            dout = MAX_EXT[DATA_W-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_EXT) begin
            dout = MIN_EXT[DATA_W-1:0];
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/svm_sv_accumulator.sv
// Streaming MAC over NUM_SV (alpha_y, kernel) pairs, plus bias, saturated to Q16.16.
module svm_sv_accumulator #(
    parameter int DATA_W    = svm_pkg::DATA_W,
    parameter int FRAC_BITS = svm_pkg::FRAC_BITS,
    parameter int NUM_SV    = 11237,
    parameter int CNT_W     = 14,
    parameter int ACC_W     = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    output logic              busy,
    svm_sv_accumulator_if.slave bus
);
    import svm_pkg::*;

    acc_state_t               state, state_nx;
    logic [CNT_W-1:0]         cnt;
    logic signed [2*DATA_W-1:0] prod_q;
    logic                     prod_vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [DATA_W-1:0] bias_q;
    logic signed [DATA_W-1:0] narrow_val;
    logic                     narrow_sat;
    logic                     accept;
    logic                     last_beat;

    assign bus.in_ready  = (state == ACCUM) && (cnt < CNT_W'(NUM_SV));
    assign bus.out_valid = (state == OUTPUT);
    assign busy          = (state != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign last_beat     = accept && (cnt == CNT_W'(NUM_SV - 1));

    // Bias aligned to the Q.32 accumulator point before narrowing.
    assign sum = acc + (ACC_W'(bias_q) <<< FRAC_BITS);

    svm_sat_narrow #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_narrow (
        .din  (sum),
        .dout (narrow_val),
        .sat  (narrow_sat)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)         state_nx = ACCUM;
            ACCUM:   if (last_beat)     state_nx = DRAIN;
            DRAIN:                      state_nx = FINAL;
            FINAL:                      state_nx = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt                       <= '0;
            prod_q                    <= '0;
            prod_vld                  <= 1'b0;
            acc                       <= '0;
            bias_q                    <= '0;
            bus.decision_value        <= '0;
            bus.classification_result <= 1'b0;
            bus.sat_flag              <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt      <= '0;
            acc      <= '0;
            prod_vld <= 1'b0;
            bias_q   <= bias;
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod_q <= (2*DATA_W)'($signed(bus.in_alpha)) * (2*DATA_W)'($signed(bus.in_kernel));
                cnt    <= cnt + CNT_W'(1);
            end
            if (prod_vld) acc <= acc + ACC_W'(prod_q);
            if (state == FINAL) begin
                bus.decision_value        <= narrow_val;
                bus.classification_result <= !narrow_val[DATA_W-1] && (|narrow_val);
                bus.sat_flag              <= narrow_sat;
            end
        end
    end
endmodule

// File: tb/tb_svm_sv_accumulator.sv
// Directed vector bench for svm_sv_accumulator with NUM_SV=4.
module tb_svm_sv_accumulator;
    import svm_pkg::*;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [31:0] k;
        logic [31:0] dv;
        logic        cls;
        logic        sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic        busy;
    int          total = 0;
    int          bad = 0;
    vec_t        tv[7];

    svm_sv_accumulator_if #(.DATA_W(32)) bus ();

    svm_sv_accumulator #(
        .DATA_W(32), .FRAC_BITS(16), .NUM_SV(4), .CNT_W(3), .ACC_W(80)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bias  (bias),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One classification; beats fed with optional random bubbles, optional
    // start glitch mid-stream and optional out_ready stall before handshake.
    task automatic run(input string nm, input vec_t v, input bit rnd, input bit glitch,
                       input int stall);
        int  n_acc;
        int  guard;
        int  lat;
        bit  ok;
        @(negedge clk);
        start = 1'b1;
        bias  = v.b;
        @(negedge clk);
        start = 1'b0;
        bias  = 32'hDEAD_BEEF;
        n_acc = 0;
        guard = 0;
        while (n_acc < 4 && guard < 200) begin
            bus.in_valid  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.in_alpha  = v.a;
            bus.in_kernel = v.k;
            start = (glitch && n_acc == 1);
            ok = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (ok) n_acc++;
            guard++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        if (n_acc < 4) chk({nm, " beats accepted"}, n_acc, 4);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 3);
        chk({nm, " dv"}, bus.decision_value, v.dv);
        chk({nm, " class"}, {31'd0, bus.classification_result}, {31'd0, v.cls});
        chk({nm, " sat"}, {31'd0, bus.sat_flag}, {31'd0, v.sat});
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, " stall valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({nm, " stall dv"}, bus.decision_value, v.dv);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({nm, " valid after hs"}, {31'd0, bus.out_valid}, 32'd0);
        chk({nm, " busy after hs"}, {31'd0, busy}, 32'd0);
        chk({nm, " dv kept"}, bus.decision_value, v.dv);
    endtask

    initial begin
        int seen;
        tv[0] = '{32'hFFFA_0000, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 1'b1, 1'b0};
        tv[1] = '{32'hFFFA_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFE_0000, 1'b0, 1'b0};
        tv[2] = '{32'hFFFA_0000, 32'h0001_0000, 32'h0001_8000, 32'h0000_0000, 1'b0, 1'b0};
        tv[3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tv[4] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
        tv[5] = '{32'h0000_0000, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_0000, 1'b0, 1'b0};
        tv[6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_alpha  = '0;
        bus.in_kernel = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset dv", bus.decision_value, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Beats offered in IDLE must not be consumed.
        bus.in_valid  = 1'b1;
        bus.in_alpha  = 32'h7FFF_FFFF;
        bus.in_kernel = 32'h7FFF_FFFF;
        repeat (3) @(negedge clk);
        chk("idle in_ready", {31'd0, bus.in_ready}, 32'd0);

        for (int i = 0; i < 7; i++) run($sformatf("vec%0d", i), tv[i], 1'b0, 1'b0, 0);

        run("bubbles", tv[0], 1'b1, 1'b0, 0);
        run("stall5", tv[1], 1'b0, 1'b0, 5);
        run("start_glitch", tv[0], 1'b0, 1'b1, 0);

        // Abort mid-run: two beats in, then asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        bias  = 32'hFFFA_0000;
        @(negedge clk);
        start         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_alpha  = 32'h0010_0000;
        bus.in_kernel = 32'h0010_0000;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("abort dv", bus.decision_value, 32'd0);
        chk("abort class", {31'd0, bus.classification_result}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort no output", seen, 0);
        run("after_abort", tv[1], 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
